// File: rtl/matrix2x2_stream_ctrl_if.sv
// ---------------------------------------------------------------------------
// matrix2x2_stream_ctrl_if
// Byte-stream handshake bundle for matrix2x2_stream_ctrl.
//   in_valid / in_ready / in_data   : element input stream (A then B)
//   out_valid / out_ready / out_data / out_last : result byte stream
// Modports:
//   slave  : the stream controller side (consumes elements, produces results)
//   master : the environment side (produces elements, consumes results)
// ---------------------------------------------------------------------------
interface matrix2x2_stream_ctrl_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/matrix2x2_stream_ctrl.sv
// ---------------------------------------------------------------------------
// matrix2x2_stream_ctrl
// Byte-stream front/back end for a 2x2 parallel matrix multiplier.
// Packs 8 serial elements (A row-major, then B row-major) into mat_a/mat_b,
// pulses mul_start, waits MUL_LATENCY cycles, captures mat_res and streams it
// back out as 4 bytes (r00, r01, r10, r11) with out_last on r11.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   s_if       stream handshake bundle (slave modport)
//   mat_a      packed A = {a00,a01,a10,a11}
//   mat_b      packed B, same packing
//   mul_start  one-cycle pulse when mat_a/mat_b become stable
//   mat_res    packed product from the multiplier
//   done_count completed-result counter (only with MATRIX_STREAM_CNT_EN)
//
// Optional feature macro: MATRIX_STREAM_CNT_EN adds done_count[15:0].
// Parameter MUL_LATENCY: cycles from stable operands to valid mat_res (1..15).
// ---------------------------------------------------------------------------
module matrix2x2_stream_ctrl #(
    parameter int unsigned MUL_LATENCY = 32'd2
) (
    input  logic                           clk,
    input  logic                           rst,
    matrix2x2_stream_ctrl_if.slave         s_if,
    output logic [31:0]                    mat_a,
    output logic [31:0]                    mat_b,
    output logic                           mul_start,
    input  logic [31:0]                    mat_res
`ifdef MATRIX_STREAM_CNT_EN
    ,output logic [15:0]                   done_count
`endif
);

    localparam logic [3:0] LAT_C = 4'(MUL_LATENCY);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_WAIT   = 2'd2,
        ST_SEND   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;          // elements accepted in current load phase
    logic [3:0]  wait_q, wait_d;        // edges elapsed since the 8th accept
    logic [1:0]  idx_q, idx_d;          // result byte currently presented
    logic [31:0] mat_a_q, mat_a_d;
    logic [31:0] mat_b_q, mat_b_d;
    logic [31:0] res_q, res_d;
    logic        in_ready_q, in_ready_d;
    logic        mul_start_q, mul_start_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
`ifdef MATRIX_STREAM_CNT_EN
    logic [15:0] done_cnt_q, done_cnt_d;
`endif

    logic in_acc_s;
    logic out_acc_s;

    // Byte i of a packed word, i=0 selects the most significant byte (r00).
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    byte_sel = w[31:24];
            2'd1:    byte_sel = w[23:16];
            2'd2:    byte_sel = w[15:8];
            default: byte_sel = w[7:0];
        endcase
    endfunction

    assign in_acc_s  = s_if.in_valid & in_ready_q;
    assign out_acc_s = out_valid_q & s_if.out_ready;

    // Next-state and output decode for the load / wait / send sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        idx_d       = idx_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        mul_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
`ifdef MATRIX_STREAM_CNT_EN
        done_cnt_d  = done_cnt_q;
`endif
        case (state_q)
            ST_LOAD_A: begin
                if (in_acc_s) begin
                    mat_a_d = {mat_a_q[23:0], s_if.in_data};
                    cnt_d   = cnt_q + 2'd1;     // wraps to 0 after the 4th element
                    if (cnt_q == 2'd3) begin
                        state_d = ST_LOAD_B;
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end else begin
                    state_d = ST_LOAD_A;
                end
            end
            ST_LOAD_B: begin
                if (in_acc_s) begin
                    mat_b_d = {mat_b_q[23:0], s_if.in_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // This edge is E0: operands final, start the multiplier.
                        state_d     = ST_WAIT;
                        in_ready_d  = 1'b0;
                        mul_start_d = 1'b1;
                        wait_d      = 4'd1;
                    end else begin
                        state_d = ST_LOAD_B;
                    end
                end else begin
                    state_d = ST_LOAD_B;
                end
            end
            ST_WAIT: begin
                // wait_q holds k during the cycle that ends at edge E(k).
                if (wait_q == LAT_C) begin
                    res_d       = mat_res;
                    state_d     = ST_SEND;
                    out_valid_d = 1'b1;
                    out_data_d  = mat_res[31:24];
                    out_last_d  = 1'b0;
                    idx_d       = 2'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_SEND: begin
                if (out_acc_s) begin
                    if (idx_q == 2'd3) begin
                        state_d     = ST_LOAD_A;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        in_ready_d  = 1'b1;
                        cnt_d       = 2'd0;
`ifdef MATRIX_STREAM_CNT_EN
                        done_cnt_d  = done_cnt_q + 16'd1;
`endif
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        out_data_d = byte_sel(res_q, idx_q + 2'd1);
                        out_last_d = (idx_q == 2'd2);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d    = ST_LOAD_A;
                cnt_d      = 2'd0;
                in_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD_A;
            cnt_q       <= 2'd0;
            wait_q      <= 4'd0;
            idx_q       <= 2'd0;
            mat_a_q     <= 32'd0;
            mat_b_q     <= 32'd0;
            res_q       <= 32'd0;
            in_ready_q  <= 1'b1;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_last_q  <= 1'b0;
`ifdef MATRIX_STREAM_CNT_EN
            done_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            idx_q       <= idx_d;
            mat_a_q     <= mat_a_d;
            mat_b_q     <= mat_b_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            mul_start_q <= mul_start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
`ifdef MATRIX_STREAM_CNT_EN
            done_cnt_q  <= done_cnt_d;
`endif
        end
    end

    assign mat_a          = mat_a_q;
    assign mat_b          = mat_b_q;
    assign mul_start      = mul_start_q;
    assign s_if.in_ready  = in_ready_q;
    assign s_if.out_valid = out_valid_q;
    assign s_if.out_data  = out_data_q;
    assign s_if.out_last  = out_last_q;
`ifdef MATRIX_STREAM_CNT_EN
    assign done_count     = done_cnt_q;
`endif

endmodule
